// File: rtl/demux_12_pkg.sv
// Shared definitions for the 1:2 nibble demux at the receive end of the alternating mux link.
package demux_12_pkg;

    typedef enum logic {
        EXP_L1 = 1'b0,
        EXP_L0 = 1'b1
    } state_e;

    // Lane carried by the first beat of each pair; the mux uses the same value.
    localparam int unsigned FIRST_LANE = 1;

    localparam state_e START_STATE = (FIRST_LANE == 1) ? EXP_L1 : EXP_L0;

endpackage

// File: rtl/demux_12_if.sv
// Serial-in / paired-out bus between the demux and its neighbours.
interface demux_12_if #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned COUNT_W = 8
);
    logic [WIDTH-1:0]   data_in;
    logic               valid_in;
    logic               resync;
    logic [WIDTH-1:0]   data_0;
    logic [WIDTH-1:0]   data_1;
    logic               valid_out;
    logic               pending;
    logic [COUNT_W-1:0] pair_count;

    modport master (
        output data_in, valid_in, resync,
        input  data_0, data_1, valid_out, pending, pair_count
    );

    modport slave (
        input  data_in, valid_in, resync,
        output data_0, data_1, valid_out, pending, pair_count
    );
endinterface

// File: rtl/demux_12_pair_counter.sv
// Wrapping count of completed pairs.
module demux_12_pair_counter #(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    output logic [COUNT_W-1:0] o_count
);
    logic [COUNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + COUNT_W'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/demux_12.sv
// Reassembles lane-1/lane-0 beat pairs from one serial lane into parallel words.
module demux_12
    import demux_12_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned COUNT_W = 8
) (
    input  logic        clk,
    input  logic        reset_L,
    demux_12_if.slave   bus
);
    state_e             r_state;
    state_e             w_next_state;
    logic [WIDTH-1:0]   r_hold;
    logic [WIDTH-1:0]   r_data_0;
    logic [WIDTH-1:0]   r_data_1;
    logic               r_valid_out;
    logic               w_load_hold;
    logic               w_clear_hold;
    logic               w_complete;
    logic [COUNT_W-1:0] w_pair_count;

    // State register plus the hold/output registers it steers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= START_STATE;
            r_hold      <= '0;
            r_data_0    <= '0;
            r_data_1    <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_valid_out <= w_complete;
            if (w_load_hold) begin
                r_hold <= bus.data_in;
            end else if (w_clear_hold) begin
                r_hold <= '0;
            end
            if (w_complete) begin
                r_data_0 <= bus.data_in;
                r_data_1 <= r_hold;
            end
        end
    end

    // Resync overrides pairing: a simultaneous beat restarts a pair as lane 1.
    always_comb begin
        w_next_state = r_state;
        w_load_hold  = 1'b0;
        w_clear_hold = 1'b0;
        w_complete   = 1'b0;
        if (bus.resync) begin
            if (bus.valid_in) begin
                w_load_hold  = 1'b1;
                w_next_state = EXP_L0;
            end else begin
                w_clear_hold = 1'b1;
                w_next_state = EXP_L1;
            end
        end else if (bus.valid_in) begin
            case (r_state)
                EXP_L1: begin
                    w_load_hold  = 1'b1;
                    w_next_state = EXP_L0;
                end
                EXP_L0: begin
                    w_complete   = 1'b1;
                    w_next_state = EXP_L1;
                end
                default: w_next_state = START_STATE;
            endcase
        end
    end

    demux_12_pair_counter #(
        .COUNT_W (COUNT_W)
    ) u_pair_counter (
        .clk     (clk),
        .rst_n   (reset_L),
        .i_en    (w_complete),
        .o_count (w_pair_count)
    );

    assign bus.data_0     = r_data_0;
    assign bus.data_1     = r_data_1;
    assign bus.valid_out  = r_valid_out;
    assign bus.pending    = (r_state == EXP_L0);
    assign bus.pair_count = w_pair_count;
endmodule

// File: tb/tb_demux_12.sv
// Directed bench for demux_12: an 8-bit-counter instance and a 2-bit-counter instance share stimulus.
module tb_demux_12;
    logic clk;
    logic reset_L;
    int   n_pass;
    int   n_total;

    demux_12_if #(.WIDTH(4), .COUNT_W(8)) bus ();
    demux_12_if #(.WIDTH(4), .COUNT_W(2)) bus2 ();

    demux_12 #(.WIDTH(4), .COUNT_W(8)) u_dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus.slave)
    );

    demux_12 #(.WIDTH(4), .COUNT_W(2)) u_dut2 (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Apply one cycle of input, then sample just after the edge that consumed it.
    task automatic beat(input logic [3:0] d, input logic v, input logic r);
        bus.data_in   = d;
        bus.valid_in  = v;
        bus.resync    = r;
        bus2.data_in  = d;
        bus2.valid_in = v;
        bus2.resync   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_pair(input string tag, input logic [3:0] d1, input logic [3:0] d0,
                              input logic [7:0] cnt);
        check({tag, ".valid"}, 32'(bus.valid_out), 32'd1);
        check({tag, ".d1"},    32'(bus.data_1),    32'(d1));
        check({tag, ".d0"},    32'(bus.data_0),    32'(d0));
        check({tag, ".cnt"},   32'(bus.pair_count), 32'(cnt));
        check({tag, ".pend"},  32'(bus.pending),   32'd0);
    endtask

    initial begin
        logic [3:0] a;
        logic [3:0] b;
        n_pass  = 0;
        n_total = 0;
        reset_L = 1'b0;
        beat(4'h0, 1'b0, 1'b0);
        check("rst.d0",   32'(bus.data_0), 32'd0);
        check("rst.d1",   32'(bus.data_1), 32'd0);
        check("rst.valid",32'(bus.valid_out), 32'd0);
        check("rst.pend", 32'(bus.pending), 32'd0);
        check("rst.cnt",  32'(bus.pair_count), 32'd0);
        #3 reset_L = 1'b1;
        @(posedge clk); #1;

        // Basic pair
        beat(4'hA, 1'b1, 1'b0);
        check("t1.pend", 32'(bus.pending), 32'd1);
        check("t1.valid0", 32'(bus.valid_out), 32'd0);
        beat(4'h5, 1'b1, 1'b0);
        check_pair("t1", 4'hA, 4'h5, 8'd1);
        beat(4'h0, 1'b0, 1'b0);
        check("t1.strobe", 32'(bus.valid_out), 32'd0);
        check("t1.hold1", 32'(bus.data_1), 32'hA);

        // Back-to-back pairs
        beat(4'h3, 1'b1, 1'b0);
        check("t2.v_a", 32'(bus.valid_out), 32'd0);
        beat(4'hC, 1'b1, 1'b0);
        check_pair("t2a", 4'h3, 4'hC, 8'd2);
        beat(4'h7, 1'b1, 1'b0);
        check("t2.v_b", 32'(bus.valid_out), 32'd0);
        check("t2.keep0", 32'(bus.data_0), 32'hC);
        beat(4'hE, 1'b1, 1'b0);
        check_pair("t2b", 4'h7, 4'hE, 8'd3);

        // Gap inside a pair
        beat(4'h9, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            beat(4'h4, 1'b0, 1'b0);
            check("t3.pend", 32'(bus.pending), 32'd1);
            check("t3.valid", 32'(bus.valid_out), 32'd0);
            check("t3.d0", 32'(bus.data_0), 32'hE);
            check("t3.d1", 32'(bus.data_1), 32'h7);
        end
        beat(4'h2, 1'b1, 1'b0);
        check_pair("t3", 4'h9, 4'h2, 8'd4);

        // Resync together with a beat in EXP_L0
        beat(4'h1, 1'b1, 1'b0);
        beat(4'h6, 1'b1, 1'b1);
        check("t4.valid", 32'(bus.valid_out), 32'd0);
        check("t4.pend", 32'(bus.pending), 32'd1);
        check("t4.cnt", 32'(bus.pair_count), 32'd4);
        beat(4'hB, 1'b1, 1'b0);
        check_pair("t4", 4'h6, 4'hB, 8'd5);

        // Resync alone drops the held word
        beat(4'h8, 1'b1, 1'b0);
        beat(4'h0, 1'b0, 1'b1);
        check("t4b.pend", 32'(bus.pending), 32'd0);
        check("t4b.valid", 32'(bus.valid_out), 32'd0);
        check("t4b.cnt", 32'(bus.pair_count), 32'd5);
        beat(4'h4, 1'b1, 1'b0);
        check("t4b.pend2", 32'(bus.pending), 32'd1);
        beat(4'h3, 1'b1, 1'b0);
        check_pair("t4b", 4'h4, 4'h3, 8'd6);

        // Asynchronous reset mid-pair
        beat(4'hD, 1'b1, 1'b0);
        check("t5.pend", 32'(bus.pending), 32'd1);
        bus.valid_in  = 1'b0;
        bus2.valid_in = 1'b0;
        #2 reset_L = 1'b0;
        #1;
        check("t5.d0",   32'(bus.data_0), 32'd0);
        check("t5.d1",   32'(bus.data_1), 32'd0);
        check("t5.pend", 32'(bus.pending), 32'd0);
        check("t5.cnt",  32'(bus.pair_count), 32'd0);
        check("t5.cnt2", 32'(bus2.pair_count), 32'd0);
        #1 reset_L = 1'b1;
        beat(4'hF, 1'b1, 1'b0);
        beat(4'h0, 1'b1, 1'b0);
        check_pair("t5", 4'hF, 4'h0, 8'd1);
        check("t6.cnt2_1", 32'(bus2.pair_count), 32'd1);

        // 2-bit counter wrap: 1,2,3,0,1
        for (int i = 2; i <= 5; i++) begin
            beat(4'h1, 1'b1, 1'b0);
            beat(4'h2, 1'b1, 1'b0);
            check("t6.cnt2", 32'(bus2.pair_count), 32'(i % 4));
        end
        check("t6.cnt", 32'(bus.pair_count), 32'd5);

        // Loopback through an alternating mux model: lane 1 first, then lane 0
        for (int i = 0; i < 8; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            beat(a, 1'b1, 1'b0);
            beat(b, 1'b1, 1'b0);
            check_pair("loop", a, b, 8'(6 + i));
        end

        // 8-bit counter wrap after 256 pairs
        reset_L = 1'b0;
        #2 reset_L = 1'b1;
        for (int i = 0; i < 256; i++) begin
            beat(4'h5, 1'b1, 1'b0);
            beat(4'hA, 1'b1, 1'b0);
        end
        check("t7.wrap", 32'(bus.pair_count), 32'd0);
        check("t7.valid", 32'(bus.valid_out), 32'd1);
        beat(4'h5, 1'b1, 1'b0);
        beat(4'hA, 1'b1, 1'b0);
        check("t7.after", 32'(bus.pair_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/demux_12.md
Name: demux_12

Overview:
- Inverse of the team's 2:1 alternating nibble mux.
- Accepts a single serial lane carrying interleaved beats in fixed order: lane-1 word first, then lane-0 word.
- Reassembles each pair and presents both words in parallel with a one-cycle valid strobe.
- Sits at the receive end of the mux link. Feeds downstream logic that consumes data_0/data_1 pairs.

Parameters:
- WIDTH, 4, width of each data word.
- COUNT_W, 8, width of the completed-pair counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_L  input  1  asynchronous active-low reset.
- data_in  input  WIDTH  serial input word.
- valid_in  input  1  data_in carries a valid beat this cycle.
- resync  input  1  force realignment: next accepted beat is treated as a lane-1 word.
- data_0  output  WIDTH  reassembled lane-0 word (registered).
- data_1  output  WIDTH  reassembled lane-1 word (registered).
- valid_out  output  1  one-cycle strobe: data_0/data_1 updated with a new pair.
- pending  output  1  high while a lane-1 word is held and its lane-0 partner is awaited.
- pair_count  output  COUNT_W  number of completed pairs, modulo 2^COUNT_W.

Behaviour:
- Reset, asynchronous on reset_L low:
  - data_0, data_1, valid_out, pending and pair_count all go to 0.
  - Internal hold register goes to 0.
  - State goes to EXP_L1.
  - Reset asserted mid-pair discards the held word; no valid_out is generated for it.
- States: EXP_L1 (awaiting lane-1 word) and EXP_L0 (awaiting lane-0 word). pending = (state == EXP_L0), registered.
- EXP_L1, valid_in=1: hold <= data_in; next state EXP_L0.
- EXP_L0, valid_in=1:
  - data_0 <= data_in; data_1 <= hold; valid_out <= 1.
  - pair_count <= pair_count+1; next state EXP_L1.
- valid_in=0: state, hold and data outputs unchanged; valid_out <= 0.
- valid_out is high for exactly one cycle per completed pair.
- Latency: valid_out and the new data_0/data_1 are visible the cycle after the lane-0 beat is sampled.
- Back-to-back pairs (valid_in held high) produce valid_out every second cycle.
- data_0/data_1 hold their last values between pairs. They never change without valid_out.
- resync=1 with valid_in=0: state <= EXP_L1, hold discarded, valid_out <= 0, pair_count unchanged.
- resync=1 with valid_in=1 (simultaneous): resync wins the alignment, and the beat is taken as a lane-1 word.
  - hold <= data_in; next state EXP_L0.
  - No pair completes that cycle; valid_out <= 0, even if the state was EXP_L0.
- pair_count wraps from 2^COUNT_W-1 to 0 with no flag.
- No backpressure: the block is always ready; every valid_in beat is consumed.
- Default link order is the mux's order: first beat after reset goes to lane 1.

Decomposition:
- Shared package holds:
  - State enum: EXP_L1 = 1'b0, EXP_L0 = 1'b1.
  - Lane-order constant FIRST_LANE = 1, shared with the mux so both ends agree.
- Sub-module pair_counter (COUNT_W-bit wrapping incrementer with enable and async reset) is natural but optional. Everything else stays in one module.

Test Plan:
- Reset, then valid_in=1 with data_in 4'hA, 4'h5 -> one cycle later: data_1=4'hA, data_0=4'h5, valid_out=1 for one cycle, pair_count=1, pending 1 then 0.
- Continuous valid_in with 3,C,7,E -> valid_out strobes every 2nd cycle; pairs (data_1,data_0) = (3,C) then (7,E); pair_count=2.
- Gapped input: beat 4'h9, three idle cycles, beat 4'h2 -> pending=1 through the gap; data outputs unchanged until (9,2) appears with valid_out.
- Mid-pair resync: beat 4'h1, resync with valid_in=1 and data_in 4'h6, then beat 4'hB -> no valid_out on the resync cycle; output pair (6,B); 4'h1 discarded.
- reset_L pulsed low asynchronously between clock edges while pending=1 -> all outputs 0 immediately. Next beats 4'hF, 4'h0 -> pair (F,0), pair_count=1.
- COUNT_W=2: drive 5 pairs -> pair_count sequence 1,2,3,0,1.
- Loopback with the mux: feed its data_out into data_in with valid_in=1 -> recovered data_0/data_1 match the mux inputs.
